ps2_host_tx: RTL and testbench

- Hardware PS/2 host-to-device transmitter; sends command bytes (LED set 0xED, reset 0xFF, rate 0xF3, ...) to keyboard/mouse on the PMOD PS/2 port.
- Drives clock and data lines open-drain via SB_IO output-enables: oe=1 pulls low, oe=0 releases to pull-up.
- Sits beside the CPU's bit-banged PS/2 receive path; the SoC presents a byte and reads status through I/O ports.

---
 rtl/ps2_host_tx.sv | 189 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: open-drain byte send with odd parity, ACK check and timeout.
// Build option PS2_HOST_TX_FILTER_EN adds an 8-sample stability filter on the synced clock.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 4000,
    parameter int unsigned TIMEOUT_CYCLES = 600000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk_core,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       ack_ok,
    output logic       err
);
    localparam int unsigned MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                           : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_REL} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;
    logic                   clk_prev;
    logic                   fall;
    logic                   timed_out;
    logic [CNT_W-1:0]       cnt;
    logic [8:0]             frame;
    logic [3:0]             idx;

    // Idle bus is high, so synchronizers come out of reset high to avoid a phantom fall.
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
        end
    end

    assign data_s = data_sync[SYNC_STAGES-1];

`ifdef PS2_HOST_TX_FILTER_EN
    logic       clk_filt;
    logic [2:0] filt_cnt;

    // Filtered clock follows the synced clock only after 8 consecutive differing samples.
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            clk_filt <= 1'b1;
            filt_cnt <= 3'd0;
        end else if (clk_sync[SYNC_STAGES-1] == clk_filt) begin
            filt_cnt <= 3'd0;
        end else if (filt_cnt == 3'd7) begin
            clk_filt <= clk_sync[SYNC_STAGES-1];
            filt_cnt <= 3'd0;
        end else begin
            filt_cnt <= filt_cnt + 3'd1;
        end
    end

    assign clk_s = clk_filt;
`else
    assign clk_s = clk_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) clk_prev <= 1'b1;
        else          clk_prev <= clk_s;
    end

    assign fall      = clk_prev & ~clk_s;
    assign timed_out = (cnt == TIMEOUT_LAST);

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            tx_ready    <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            ack_ok      <= 1'b0;
            err         <= 1'b0;
            cnt         <= '0;
            frame       <= 9'd0;
            idx         <= 4'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        frame      <= {~^tx_data, tx_data};
                        ack_ok     <= 1'b0;
                        err        <= 1'b0;
                        cnt        <= '0;
                        ps2_clk_oe <= 1'b1;
                        tx_ready   <= 1'b0;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == INHIBIT_LAST) begin
                        ps2_data_oe <= 1'b1;
                        cnt         <= '0;
                        state       <= REQ;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                REQ: begin
                    ps2_clk_oe <= 1'b0;
                    idx        <= 4'd0;
                    cnt        <= '0;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    if (fall) begin
                        cnt <= '0;
                        if (idx == 4'd9) begin
                            ps2_data_oe <= 1'b0;
                            state       <= ACK;
                        end else begin
                            ps2_data_oe <= ~frame[0];
                            frame       <= {1'b0, frame[8:1]};
                            idx         <= idx + 4'd1;
                        end
                    end else if (timed_out) begin
                        ps2_data_oe <= 1'b0;
                        err         <= 1'b1;
                        ack_ok      <= 1'b0;
                        done        <= 1'b1;
                        tx_ready    <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ACK: begin
                    if (fall) begin
                        ack_ok <= ~data_s;
                        err    <= data_s;
                        cnt    <= '0;
                        state  <= WAIT_REL;
                    end else if (timed_out) begin
                        err      <= 1'b1;
                        ack_ok   <= 1'b0;
                        done     <= 1'b1;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_REL: begin
                    if (clk_s && data_s) begin
                        done     <= 1'b1;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end else if (timed_out) begin
                        err      <= 1'b1;
                        ack_ok   <= 1'b0;
                        done     <= 1'b1;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_ready    <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device, shortened timing parameters.
// With PS2_HOST_TX_FILTER_EN defined it also injects single-cycle clock glitches.
module tb_ps2_host_tx;
    localparam int unsigned INHIBIT = 40;
    localparam int unsigned TIMEOUT = 3000;
    localparam int          HALF    = 30;

    logic       clk_core = 1'b0;
    logic       reset_n  = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       done;
    logic       ack_ok;
    logic       err;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clk_line;
    logic       data_line;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    assign clk_line  = !(ps2_clk_oe || dev_clk_low);
    assign data_line = !(ps2_data_oe || dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT),
        .SYNC_STAGES   (2)
    ) dut (
        .clk_core   (clk_core),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (clk_line),
        .ps2_data_in(data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .done       (done),
        .ack_ok     (ack_ok),
        .err        (err)
    );

    always #5 clk_core = ~clk_core;

    always @(negedge clk_core) if (done === 1'b1) done_cnt++;

    // Wire-level frame the device should see: 8 data bits LSB first, odd parity, released stop.
    function automatic logic [9:0] expected_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'((b >> i) & 8'd1);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
    endfunction

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int guard = 0;
        while (tx_ready !== 1'b1 && guard < 200) begin
            @(negedge clk_core);
            guard++;
        end
        ok       = (tx_ready === 1'b1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk_core);
        tx_valid = 1'b0;
    endtask

    // Starts on the first negedge after accept; ends on the first negedge with the clock released.
    task automatic measure_inhibit(output int hold, output int overlap, output int ready_hi);
        int guard = 0;
        hold = 0; overlap = 0; ready_hi = 0;
        while (ps2_data_oe !== 1'b1 && guard < 4 * INHIBIT) begin
            if (ps2_clk_oe === 1'b1) hold++;
            if (tx_ready !== 1'b0) ready_hi++;
            @(negedge clk_core);
            guard++;
        end
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1 && guard < 8 * INHIBIT) begin
            overlap++;
            if (tx_ready !== 1'b0) ready_hi++;
            @(negedge clk_core);
            guard++;
        end
    endtask

    task automatic run_device(input int npulse, input bit ack, input bit glitch, input bit hold_valid,
                              input logic [7:0] busy_byte, output logic [9:0] seen,
                              output logic start, output int ready_hi);
        seen = '0; ready_hi = 0;
        start = data_line;
        if (hold_valid) begin
            tx_data  = busy_byte;
            tx_valid = 1'b1;
        end
        for (int i = 0; i < npulse; i++) begin
            for (int k = 0; k < HALF; k++) begin
                dev_clk_low = glitch && (k == 5);
                if (i == 10 && k == 0) tx_valid = 1'b0;
                if (i == 10 && k == HALF / 2) dev_data_low = ack;
                if (tx_ready === 1'b1) ready_hi++;
                @(negedge clk_core);
            end
            dev_clk_low = 1'b1;
            for (int k = 0; k < HALF - 1; k++) begin
                if (tx_ready === 1'b1) ready_hi++;
                @(negedge clk_core);
            end
            if (i < 10) seen[i] = data_line;
            @(negedge clk_core);
        end
        dev_clk_low = 1'b0;
        tx_valid    = 1'b0;
        repeat (HALF / 2) @(negedge clk_core);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit got);
        int guard = 0;
        while (done_cnt == d0 && guard < budget) begin
            @(negedge clk_core);
            guard++;
        end
        got = (done_cnt != d0);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk_core);
        reset_n = 1'b1;
        @(negedge clk_core);
        checks += 5;
        if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
        if (ps2_clk_oe !== 1'b0) begin failures++; $display("FAIL reset_clk_oe got=%b exp=0", ps2_clk_oe); end
        if (ps2_data_oe !== 1'b0) begin failures++; $display("FAIL reset_data_oe got=%b exp=0", ps2_data_oe); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        if ({ack_ok, err} !== 2'b00) begin failures++; $display("FAIL reset_status got=%b exp=00", {ack_ok, err}); end
    endtask

    // Full transfer; status checks and frame comparison against the model.
    task automatic transfer(input string name, input logic [7:0] b, input bit ack, input bit glitch,
                            input bit hold_valid, input bit check_inhibit);
        bit ok, got;
        int hold, overlap, rdy_inh, rdy_dev, d0;
        logic [9:0] seen, exp;
        logic start;
        exp = expected_frame(b);
        d0 = done_cnt;
        send_byte(b, ok);
        checks++;
        if (!ok || tx_ready !== 1'b0) begin
            failures++; $display("FAIL %s accept ready_ok=%b tx_ready=%b exp_ready=0", name, ok, tx_ready);
        end
        measure_inhibit(hold, overlap, rdy_inh);
        if (check_inhibit) begin
            checks += 3;
            if (hold != INHIBIT) begin failures++; $display("FAIL %s inhibit_len got=%0d exp=%0d", name, hold, INHIBIT); end
            if (overlap != 1) begin failures++; $display("FAIL %s req_overlap got=%0d exp=1", name, overlap); end
            if (rdy_inh != 0) begin failures++; $display("FAIL %s ready_in_inhibit got=%0d exp=0", name, rdy_inh); end
        end
        run_device(11, ack, glitch, hold_valid, ~b, seen, start, rdy_dev);
        wait_done(d0, 200, got);
        checks += 5;
        if (start !== 1'b0) begin failures++; $display("FAIL %s start_bit got=%b exp=0", name, start); end
        if (seen !== exp) begin failures++; $display("FAIL %s frame got=%b exp=%b", name, seen, exp); end
        if (rdy_dev != 0) begin failures++; $display("FAIL %s ready_while_busy got=%0d exp=0", name, rdy_dev); end
        if (!got) begin failures++; $display("FAIL %s done_timeout got=none exp=pulse", name); end
        if ({ack_ok, err, ps2_clk_oe, ps2_data_oe} !== {ack, !ack, 2'b00}) begin
            failures++;
            $display("FAIL %s status ack_ok=%b err=%b clk_oe=%b data_oe=%b exp_ack=%b", name,
                     ack_ok, err, ps2_clk_oe, ps2_data_oe, ack);
        end
        repeat (5) @(negedge clk_core);
        checks++;
        if (done_cnt != d0 + 1 || ack_ok !== ack || ps2_clk_oe !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done dones=%0d exp=1 ack_ok=%b exp=%b clk_oe=%b", name,
                     done_cnt - d0, ack_ok, ack, ps2_clk_oe);
        end
    endtask

    task automatic test_inhibit_ack;
        transfer("ed_ack", 8'hED, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_parity;
        logic [7:0] bytes[7];
        bytes[0] = 8'h01; bytes[1] = 8'hFF; bytes[2] = 8'hF3;
        for (int i = 3; i < 7; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 7; i++) transfer($sformatf("parity_%02h", bytes[i]), bytes[i], 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_nack_busy;
        transfer("nack_busy", 8'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_timeout;
        bit ok;
        int hold, overlap, rdy, waited;
        send_byte(8'($urandom), ok);
        measure_inhibit(hold, overlap, rdy);
        waited = 0;
        while (done !== 1'b1 && waited < int'(TIMEOUT) + 100) begin
            @(negedge clk_core);
            waited++;
        end
        checks += 3;
        if (!ok || waited != int'(TIMEOUT)) begin
            failures++; $display("FAIL timeout_len got=%0d exp=%0d", waited, TIMEOUT);
        end
        if ({ack_ok, err} !== 2'b01) begin failures++; $display("FAIL timeout_status got=%b exp=01", {ack_ok, err}); end
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            failures++; $display("FAIL timeout_release got=%b exp=00", {ps2_clk_oe, ps2_data_oe});
        end
        repeat (3) @(negedge clk_core);
    endtask

    task automatic test_reset_mid;
        bit ok;
        int hold, overlap, rdy, d0;
        logic [9:0] seen;
        logic start;
        d0 = done_cnt;
        send_byte(8'h00, ok);
        measure_inhibit(hold, overlap, rdy);
        run_device(4, 1'b0, 1'b0, 1'b0, 8'h00, seen, start, rdy);
        checks++;
        if (!ok || ps2_data_oe !== 1'b1) begin
            failures++; $display("FAIL midreset_pre data_oe got=%b exp=1", ps2_data_oe);
        end
        reset_n = 1'b0;
        #1;
        checks += 2;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            failures++; $display("FAIL midreset_release got=%b exp=00", {ps2_clk_oe, ps2_data_oe});
        end
        if (tx_ready !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL midreset_ready tx_ready=%b done=%b exp=1,0", tx_ready, done);
        end
        @(negedge clk_core);
        reset_n = 1'b1;
        repeat (2 * HALF) @(negedge clk_core);
        checks++;
        if (done_cnt != d0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", done_cnt - d0); end
    endtask

`ifdef PS2_HOST_TX_FILTER_EN
    task automatic test_glitch;
        for (int i = 0; i < 2; i++) transfer("glitch", 8'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_inhibit_ack();
        test_parity();
        test_nack_busy();
        test_timeout();
        test_reset_mid();
`ifdef PS2_HOST_TX_FILTER_EN
        test_glitch();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
